// File: rtl/muldiv_alu.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_alu
// Brief    : Multi-cycle EX-stage ALU with iterative shift-add multiply and
//            restoring divide. Optional signed mult/div (ops d/e) built only
//            when MULDIV_SIGNED_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] result1,
    output logic [WIDTH-1:0] result2,
    output logic             equ,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam logic [3:0]     c_op_sll  = 4'h0;
    localparam logic [3:0]     c_op_sra  = 4'h1;
    localparam logic [3:0]     c_op_srl  = 4'h2;
    localparam logic [3:0]     c_op_mulu = 4'h3;
    localparam logic [3:0]     c_op_divu = 4'h4;
    localparam logic [3:0]     c_op_add  = 4'h5;
    localparam logic [3:0]     c_op_sub  = 4'h6;
    localparam logic [3:0]     c_op_and  = 4'h7;
    localparam logic [3:0]     c_op_or   = 4'h8;
    localparam logic [3:0]     c_op_xor  = 4'h9;
    localparam logic [3:0]     c_op_nor  = 4'ha;
    localparam logic [3:0]     c_op_slt  = 4'hb;
    localparam logic [3:0]     c_op_sltu = 4'hc;
    localparam logic [3:0]     c_op_mul  = 4'hd;
    localparam logic [3:0]     c_op_div  = 4'he;
    localparam logic [SHW-1:0] c_last    = SHW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [SHW-1:0]     r_cnt;
    logic               r_div;
    logic               r_yzero;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic [WIDTH-1:0]   r_result1, r_result2;
    logic               r_equ, r_done, r_dz;

    logic               w_is_mul, w_is_div, w_iter, w_accept, w_finish;
    logic [WIDTH-1:0]   w_mag_x, w_mag_y, w_r1;
    logic [WIDTH:0]     w_sum, w_shift;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_hi_nxt, w_lo_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;
    logic [WIDTH-1:0]   w_fin1, w_fin2;

`ifdef MULDIV_SIGNED_EN
    logic w_signed;
    logic r_neg_q, r_neg_r;

    assign w_signed = (op == c_op_mul) || (op == c_op_div);
    assign w_is_mul = (op == c_op_mulu) || (op == c_op_mul);
    assign w_is_div = (op == c_op_divu) || (op == c_op_div);
    assign w_mag_x  = (w_signed && x[WIDTH-1]) ? -x : x;
    assign w_mag_y  = (w_signed && y[WIDTH-1]) ? -y : y;
`else
    assign w_is_mul = (op == c_op_mulu);
    assign w_is_div = (op == c_op_divu);
    assign w_mag_x  = x;
    assign w_mag_y  = y;
`endif

    assign w_iter   = w_is_mul || w_is_div;
    assign w_accept = (r_state == S_IDLE) && start;

    // Single-cycle results; op d/e land in default when the signed engine is absent.
    always_comb begin
        w_r1 = '0;
        case (op)
            c_op_sll:  w_r1 = x << y[SHW-1:0];
            c_op_sra:  w_r1 = $signed(x) >>> y[SHW-1:0];
            c_op_srl:  w_r1 = x >> y[SHW-1:0];
            c_op_add:  w_r1 = x + y;
            c_op_sub:  w_r1 = x - y;
            c_op_and:  w_r1 = x & y;
            c_op_or:   w_r1 = x | y;
            c_op_xor:  w_r1 = x ^ y;
            c_op_nor:  w_r1 = ~(x | y);
            c_op_slt:  w_r1 = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            c_op_sltu: w_r1 = {{(WIDTH-1){1'b0}}, (x < y)};
            default:   w_r1 = '0;
        endcase
    end

    // Shared engine: r_hi is product-high / partial remainder, r_lo is multiplier / quotient.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_diff  = w_shift[WIDTH-1:0] - r_b;

    always_comb begin
        w_hi_nxt = w_sum[WIDTH:1];
        w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
        if (r_div) begin
            if (w_shift >= {1'b0, r_b}) begin
                w_hi_nxt = w_diff;
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_shift[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

`ifdef MULDIV_SIGNED_EN
    assign w_prod = r_neg_q ? -{w_hi_nxt, w_lo_nxt} : {w_hi_nxt, w_lo_nxt};
    assign w_quo  = r_neg_q ? -w_lo_nxt : w_lo_nxt;
    assign w_rem  = r_neg_r ? -w_hi_nxt : w_hi_nxt;
`else
    assign w_prod = {w_hi_nxt, w_lo_nxt};
    assign w_quo  = w_lo_nxt;
    assign w_rem  = w_hi_nxt;
`endif

    always_comb begin
        w_fin1 = w_prod[WIDTH-1:0];
        w_fin2 = w_prod[2*WIDTH-1:WIDTH];
        if (r_div) begin
            w_fin1 = r_yzero ? '1  : w_quo;
            w_fin2 = r_yzero ? r_x : w_rem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: if (start && w_iter) w_state_nxt = S_RUN;
            S_RUN: begin
                if (r_cnt == c_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_div     <= 1'b0;
            r_yzero   <= 1'b0;
            r_x       <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_result1 <= '0;
            r_result2 <= '0;
            r_equ     <= 1'b0;
            r_done    <= 1'b0;
            r_dz      <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_equ <= (x == y);
                if (w_iter) begin
                    r_cnt   <= '0;
                    r_div   <= w_is_div;
                    r_yzero <= (y == '0);
                    r_x     <= x;
                    r_b     <= w_mag_y;
                    r_lo    <= w_mag_x;
                    r_hi    <= '0;
`ifdef MULDIV_SIGNED_EN
                    r_neg_q <= w_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
                    r_neg_r <= w_signed && x[WIDTH-1];
`endif
                end else begin
                    r_result1 <= w_r1;
                    r_result2 <= '0;
                    r_done    <= 1'b1;
                end
            end else if (r_state == S_RUN) begin
                r_hi  <= w_hi_nxt;
                r_lo  <= w_lo_nxt;
                r_cnt <= r_cnt + SHW'(1);
                if (w_finish) begin
                    r_result1 <= w_fin1;
                    r_result2 <= w_fin2;
                    r_done    <= 1'b1;
                    if (r_div) r_dz <= r_yzero;
                end
            end
        end
    end

    assign result1 = r_result1;
    assign result2 = r_result2;
    assign equ     = r_equ;
    assign busy    = (r_state == S_RUN);
    assign done    = r_done;
    assign dz      = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_alu
// Brief    : Self-checking bench for muldiv_alu (WIDTH=32) against an
//            arithmetic reference model; honours MULDIV_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    op = '0;
    logic [W-1:0]  x = '0;
    logic [W-1:0]  y = '0;
    logic [W-1:0]  result1, result2;
    logic          equ, busy, done, dz;

    int ntests = 0;
    int nfail  = 0;
    logic exp_dz = 1'b0;

    muldiv_alu #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .x       (x),
        .y       (y),
        .result1 (result1),
        .result2 (result2),
        .equ     (equ),
        .busy    (busy),
        .done    (done),
        .dz      (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the architectural op map.
    function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r1, output logic [31:0] r2,
                                  output bit iter, output bit isdiv);
        longint     sa, sb;
        logic [63:0] p;
        logic [4:0]  sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = b[4:0];
        r1 = '0; r2 = '0; iter = 0; isdiv = 0;
        case (o)
            4'h0: r1 = a << sh;
            4'h1: r1 = 32'($signed(a) >>> sh);
            4'h2: r1 = a >> sh;
            4'h3: begin p = 64'(a) * 64'(b); r1 = p[31:0]; r2 = p[63:32]; iter = 1; end
            4'h4: begin
                iter = 1; isdiv = 1;
                if (b == 0) begin r1 = '1; r2 = a; end
                else begin r1 = a / b; r2 = a % b; end
            end
            4'h5: r1 = a + b;
            4'h6: r1 = a - b;
            4'h7: r1 = a & b;
            4'h8: r1 = a | b;
            4'h9: r1 = a ^ b;
            4'ha: r1 = ~(a | b);
            4'hb: r1 = (sa < sb) ? 32'd1 : 32'd0;
            4'hc: r1 = (a < b) ? 32'd1 : 32'd0;
`ifdef MULDIV_SIGNED_EN
            4'hd: begin p = 64'(sa * sb); r1 = p[31:0]; r2 = p[63:32]; iter = 1; end
            4'he: begin
                iter = 1; isdiv = 1;
                if (b == 0) begin r1 = '1; r2 = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r1 = a; r2 = '0; end
                else begin r1 = 32'(sa / sb); r2 = 32'(sa % sb); end
            end
`endif
            default: begin r1 = '0; r2 = '0; end
        endcase
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input string tag);
        logic [31:0] e1, e2;
        bit iter, isdiv;
        int lat, nbusy;
        model(o, a, b, e1, e2, iter, isdiv);
        if (isdiv) exp_dz = (b == 0);
        @(negedge clk);
        op = o; x = a; y = b; start = 1'b1;
        @(negedge clk);
        // Scramble inputs after acceptance; the op must use latched values.
        op = 4'($urandom); x = $urandom; y = $urandom;
        if (!hold) start = 1'b0;
        lat = 1; nbusy = 0;
        while (!done && lat <= 80) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, " done"},    64'(done),    64'd1);
        check({tag, " latency"}, 64'(lat),     iter ? 64'd33 : 64'd1);
        check({tag, " busycyc"}, 64'(nbusy),   iter ? 64'd32 : 64'd0);
        check({tag, " result1"}, 64'(result1), 64'(e1));
        check({tag, " result2"}, 64'(result2), 64'(e2));
        check({tag, " equ"},     64'(equ),     64'(a == b));
        check({tag, " dz"},      64'(dz),      64'(exp_dz));
        @(negedge clk);
        check({tag, " done1cyc"}, 64'(done),   64'd0);
        check({tag, " idle"},     64'(busy),   64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, e1, e2;
        logic [3:0]  ro;
        bit iter, isdiv;
        int ndone, n;

        repeat (3) @(negedge clk);
        check("reset result1", 64'(result1), 64'd0);
        check("reset result2", 64'(result2), 64'd0);
        check("reset flags", {60'd0, equ, busy, done, dz}, 64'd0);
        rst_n = 1'b1;

        run_op(4'h5, 32'd7, 32'hFFFF_FFFF, 0, "add");
        run_op(4'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "multu_hold");
        run_op(4'h4, 32'd100, 32'd7, 0, "divu");
        run_op(4'h4, 32'd5, 32'd0, 0, "divu_dz");
        run_op(4'h7, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, "and_keeps_dz");
        run_op(4'he, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
        run_op(4'he, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        run_op(4'hd, 32'hFFFF_FFFD, 32'd4, 0, "mul_neg");
        run_op(4'he, 32'hFFFF_FFF9, 32'd0, 0, "div_dz");
        run_op(4'h4, 32'd9, 32'd9, 0, "divu_equ");
        run_op(4'hf, 32'd1, 32'd2, 0, "op_f");
        run_op(4'hb, 32'h8000_0000, 32'd1, 0, "slt");
        run_op(4'hc, 32'h8000_0000, 32'd1, 0, "sltu");

        // Reset during RUN: immediate clear, no completion afterwards.
        @(negedge clk);
        op = 4'h3; x = 32'hDEAD_BEEF; y = 32'h1234_5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst result1", 64'(result1), 64'd0);
        check("midrst result2", 64'(result2), 64'd0);
        check("midrst flags", {60'd0, equ, busy, done, dz}, 64'd0);
        exp_dz = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst no done", 64'(ndone), 64'd0);
        run_op(4'h1, 32'h8000_0000, 32'h24, 0, "sra_after_rst");

        // Back-to-back: start held, op 7 presented in the done cycle.
        @(negedge clk);
        op = 4'h4; x = 32'd1000; y = 32'd33; start = 1'b1;
        ndone = 0; n = 0;
        while (ndone == 0 && n < 80) begin
            @(negedge clk);
            n++;
            if (done) ndone++;
        end
        check("b2b div q", 64'(result1), 64'd30);
        check("b2b div r", 64'(result2), 64'd10);
        op = 4'h7; x = 32'hFF00_FF00; y = 32'h0FF0_0FF0;
        @(negedge clk);
        start = 1'b0;
        if (done) ndone++;
        check("b2b and r1", 64'(result1), 64'h0F00_0F00);
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("b2b pulses", 64'(ndone), 64'd2);
        exp_dz = 1'b0;

        for (int i = 0; i < 50; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = ra;
                2: rb = 32'($urandom_range(1, 300));
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: ;
            endcase
            run_op(ro, ra, rb, 0, $sformatf("rnd%0d op%0h", i, ro));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
